// File: rtl/mac_lut_arbiter.sv
// Single command-port arbiter for the learning-switch MAC CAM/LUT: lookup, learn,
// register write and register read share one table port. Optional starvation guard: MAC_LUT_ARB_STARVE_GUARD_EN.
module mac_lut_arbiter #(
    parameter int NUM_OUTPUT_QUEUES = 5,
    parameter int LUT_DEPTH_BITS    = 4,
    parameter int STARVE_LIMIT      = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         lu_req,
    input  logic [47:0]                  lu_mac,
    output logic                         lu_ack,
    output logic                         lu_hit,
    output logic [NUM_OUTPUT_QUEUES-1:0] lu_oq,
    input  logic                         lrn_req,
    input  logic [LUT_DEPTH_BITS-1:0]    lrn_addr,
    input  logic [47:0]                  lrn_mac,
    input  logic [NUM_OUTPUT_QUEUES-1:0] lrn_oq,
    output logic                         lrn_ack,
    input  logic                         reg_wr_req,
    input  logic [LUT_DEPTH_BITS-1:0]    reg_wr_addr,
    input  logic [NUM_OUTPUT_QUEUES-1:0] reg_wr_oq,
    input  logic                         reg_wr_protect,
    input  logic [47:0]                  reg_wr_mac,
    output logic                         reg_wr_ack,
    input  logic                         reg_rd_req,
    input  logic [LUT_DEPTH_BITS-1:0]    reg_rd_addr,
    output logic                         reg_rd_ack,
    output logic [NUM_OUTPUT_QUEUES-1:0] reg_rd_oq,
    output logic                         reg_rd_protect,
    output logic [47:0]                  reg_rd_mac,
    output logic                         tbl_req,
    output logic [1:0]                   tbl_op,
    output logic [LUT_DEPTH_BITS-1:0]    tbl_addr,
    output logic [47:0]                  tbl_mac,
    output logic [NUM_OUTPUT_QUEUES-1:0] tbl_oq,
    output logic                         tbl_protect,
    input  logic                         tbl_done,
    input  logic                         tbl_hit,
    input  logic [NUM_OUTPUT_QUEUES-1:0] tbl_rd_oq,
    input  logic                         tbl_rd_protect,
    input  logic [47:0]                  tbl_rd_mac,
    output logic                         lut_hit,
    output logic                         lut_miss
);

    typedef enum logic [1:0] {IDLE = 2'b00, ISSUE = 2'b01, RESP = 2'b10, REG_HOLD = 2'b11} state_t;
    typedef enum logic [1:0] {G_LU = 2'b00, G_LRN = 2'b01, G_WR = 2'b10, G_RD = 2'b11} grant_t;

    localparam logic [1:0] OP_LOOKUP = 2'b00;
    localparam logic [1:0] OP_READ   = 2'b01;
    localparam logic [1:0] OP_WRITE  = 2'b10;
    localparam logic [NUM_OUTPUT_QUEUES-1:0] OQ_ZERO   = {NUM_OUTPUT_QUEUES{1'b0}};
    localparam logic [LUT_DEPTH_BITS-1:0]    ADDR_ZERO = {LUT_DEPTH_BITS{1'b0}};

    state_t state_r;
    grant_t grant_r;
    grant_t next_grant;
    logic   grant_valid;
    logic   force_reg;
    logic   reg_pending;

    assign reg_pending = reg_wr_req | reg_rd_req;

`ifdef MAC_LUT_ARB_STARVE_GUARD_EN
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    logic [CNT_W-1:0] starve_cnt_r;

    assign force_reg = reg_pending && (starve_cnt_r >= CNT_W'(STARVE_LIMIT));

    // Count datapath grants made while a register request is kept waiting
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            starve_cnt_r <= {CNT_W{1'b0}};
        end else if (!reg_pending) begin
            starve_cnt_r <= {CNT_W{1'b0}};
        end else if (state_r == IDLE && grant_valid) begin
            if (next_grant == G_WR || next_grant == G_RD) begin
                starve_cnt_r <= {CNT_W{1'b0}};
            end else if (starve_cnt_r < CNT_W'(STARVE_LIMIT)) begin
                starve_cnt_r <= starve_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                starve_cnt_r <= starve_cnt_r;
            end
        end else begin
            starve_cnt_r <= starve_cnt_r;
        end
    end
`else
    logic starve_limit_unused;
    assign starve_limit_unused = (STARVE_LIMIT > 0);
    assign force_reg = 1'b0;
`endif

    // Fixed-priority selection, overridden by the starvation guard when armed
    always_comb begin
        grant_valid = 1'b1;
        next_grant  = G_LU;
        if (force_reg) begin
            next_grant = reg_wr_req ? G_WR : G_RD;
        end else if (lu_req) begin
            next_grant = G_LU;
        end else if (lrn_req) begin
            next_grant = G_LRN;
        end else if (reg_wr_req) begin
            next_grant = G_WR;
        end else if (reg_rd_req) begin
            next_grant = G_RD;
        end else begin
            grant_valid = 1'b0;
        end
    end

    // Arbitration FSM; all outputs are registered here
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r        <= IDLE;
            grant_r        <= G_LU;
            lu_ack         <= 1'b0;
            lu_hit         <= 1'b0;
            lu_oq          <= OQ_ZERO;
            lrn_ack        <= 1'b0;
            reg_wr_ack     <= 1'b0;
            reg_rd_ack     <= 1'b0;
            reg_rd_oq      <= OQ_ZERO;
            reg_rd_protect <= 1'b0;
            reg_rd_mac     <= 48'h0;
            tbl_req        <= 1'b0;
            tbl_op         <= OP_LOOKUP;
            tbl_addr       <= ADDR_ZERO;
            tbl_mac        <= 48'h0;
            tbl_oq         <= OQ_ZERO;
            tbl_protect    <= 1'b0;
            lut_hit        <= 1'b0;
            lut_miss       <= 1'b0;
        end else begin
            lu_ack   <= 1'b0;
            lrn_ack  <= 1'b0;
            lut_hit  <= 1'b0;
            lut_miss <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (grant_valid) begin
                        grant_r <= next_grant;
                        state_r <= ISSUE;
                        tbl_req <= 1'b1;
                        case (next_grant)
                            G_LU: begin
                                tbl_op      <= OP_LOOKUP;
                                tbl_addr    <= ADDR_ZERO;
                                tbl_mac     <= lu_mac;
                                tbl_oq      <= OQ_ZERO;
                                tbl_protect <= 1'b0;
                            end
                            G_LRN: begin
                                tbl_op      <= OP_WRITE;
                                tbl_addr    <= lrn_addr;
                                tbl_mac     <= lrn_mac;
                                tbl_oq      <= lrn_oq;
                                tbl_protect <= 1'b0;
                            end
                            G_WR: begin
                                tbl_op      <= OP_WRITE;
                                tbl_addr    <= reg_wr_addr;
                                tbl_mac     <= reg_wr_mac;
                                tbl_oq      <= reg_wr_oq;
                                tbl_protect <= reg_wr_protect;
                            end
                            G_RD: begin
                                tbl_op      <= OP_READ;
                                tbl_addr    <= reg_rd_addr;
                                tbl_mac     <= 48'h0;
                                tbl_oq      <= OQ_ZERO;
                                tbl_protect <= 1'b0;
                            end
                            default: begin
                                tbl_op <= OP_LOOKUP;
                            end
                        endcase
                    end
                end
                ISSUE: begin
                    if (tbl_done) begin
                        tbl_req <= 1'b0;
                        case (grant_r)
                            G_LU: begin
                                lu_ack   <= 1'b1;
                                lu_hit   <= tbl_hit;
                                lu_oq    <= tbl_hit ? tbl_rd_oq : OQ_ZERO;
                                lut_hit  <= tbl_hit;
                                lut_miss <= ~tbl_hit;
                                state_r  <= RESP;
                            end
                            G_LRN: begin
                                lrn_ack <= 1'b1;
                                state_r <= RESP;
                            end
                            G_WR: begin
                                reg_wr_ack <= 1'b1;
                                state_r    <= REG_HOLD;
                            end
                            G_RD: begin
                                reg_rd_ack     <= 1'b1;
                                reg_rd_oq      <= tbl_rd_oq;
                                reg_rd_protect <= tbl_rd_protect;
                                reg_rd_mac     <= tbl_rd_mac;
                                state_r        <= REG_HOLD;
                            end
                            default: begin
                                state_r <= IDLE;
                            end
                        endcase
                    end
                end
                RESP: begin
                    lu_hit  <= 1'b0;
                    lu_oq   <= OQ_ZERO;
                    state_r <= IDLE;
                end
                REG_HOLD: begin
                    // Four-phase release: hold ack until the granted requester lets go
                    if ((grant_r == G_WR && !reg_wr_req) || (grant_r == G_RD && !reg_rd_req)) begin
                        reg_wr_ack <= 1'b0;
                        reg_rd_ack <= 1'b0;
                        state_r    <= IDLE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mac_lut_arbiter.sv
// Self-checking bench for mac_lut_arbiter: behavioural CAM responder plus a reference
// table of expected contents; randomized lookups, learns and register accesses.
module tb_mac_lut_arbiter;
    localparam int NQ = 5;
    localparam int AW = 4;
    localparam int DEPTH = 16;

    logic clk, reset;
    logic lu_req, lu_ack, lu_hit;
    logic [47:0] lu_mac;
    logic [NQ-1:0] lu_oq;
    logic lrn_req, lrn_ack;
    logic [AW-1:0] lrn_addr;
    logic [47:0] lrn_mac;
    logic [NQ-1:0] lrn_oq;
    logic reg_wr_req, reg_wr_protect, reg_wr_ack;
    logic [AW-1:0] reg_wr_addr;
    logic [NQ-1:0] reg_wr_oq;
    logic [47:0] reg_wr_mac;
    logic reg_rd_req, reg_rd_ack, reg_rd_protect;
    logic [AW-1:0] reg_rd_addr;
    logic [NQ-1:0] reg_rd_oq;
    logic [47:0] reg_rd_mac;
    logic tbl_req, tbl_protect, tbl_done, tbl_hit, tbl_rd_protect;
    logic [1:0] tbl_op;
    logic [AW-1:0] tbl_addr;
    logic [47:0] tbl_mac, tbl_rd_mac;
    logic [NQ-1:0] tbl_oq, tbl_rd_oq;
    logic lut_hit, lut_miss;

    int total, bad;
    int tbl_delay, wait_cnt;

    // CAM contents as modified by the DUT's commands
    logic [47:0]   mem_mac [DEPTH];
    logic [NQ-1:0] mem_oq  [DEPTH];
    logic          mem_prot[DEPTH];
    logic          mem_vld [DEPTH];
    // Contents the bench expects the table to hold
    logic [47:0]   ref_mac [DEPTH];
    logic [NQ-1:0] ref_oq  [DEPTH];
    logic          ref_prot[DEPTH];
    logic          ref_vld [DEPTH];

    mac_lut_arbiter #(.NUM_OUTPUT_QUEUES(NQ), .LUT_DEPTH_BITS(AW), .STARVE_LIMIT(8)) dut (
        .clk(clk), .reset(reset),
        .lu_req(lu_req), .lu_mac(lu_mac), .lu_ack(lu_ack), .lu_hit(lu_hit), .lu_oq(lu_oq),
        .lrn_req(lrn_req), .lrn_addr(lrn_addr), .lrn_mac(lrn_mac), .lrn_oq(lrn_oq), .lrn_ack(lrn_ack),
        .reg_wr_req(reg_wr_req), .reg_wr_addr(reg_wr_addr), .reg_wr_oq(reg_wr_oq),
        .reg_wr_protect(reg_wr_protect), .reg_wr_mac(reg_wr_mac), .reg_wr_ack(reg_wr_ack),
        .reg_rd_req(reg_rd_req), .reg_rd_addr(reg_rd_addr), .reg_rd_ack(reg_rd_ack),
        .reg_rd_oq(reg_rd_oq), .reg_rd_protect(reg_rd_protect), .reg_rd_mac(reg_rd_mac),
        .tbl_req(tbl_req), .tbl_op(tbl_op), .tbl_addr(tbl_addr), .tbl_mac(tbl_mac),
        .tbl_oq(tbl_oq), .tbl_protect(tbl_protect), .tbl_done(tbl_done), .tbl_hit(tbl_hit),
        .tbl_rd_oq(tbl_rd_oq), .tbl_rd_protect(tbl_rd_protect), .tbl_rd_mac(tbl_rd_mac),
        .lut_hit(lut_hit), .lut_miss(lut_miss)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [47:0] rand_mac();
        return 48'({$urandom(), $urandom()});
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Table responder: answers each command after tbl_delay extra cycles; result buses are noise otherwise
    initial begin
        tbl_done = 1'b0;
        wait_cnt = 0;
        for (int i = 0; i < DEPTH; i++) begin
            mem_mac[i] = 48'h0; mem_oq[i] = '0; mem_prot[i] = 1'b0; mem_vld[i] = 1'b0;
        end
        forever begin
            @(posedge clk);
            #1;
            tbl_done       = 1'b0;
            tbl_hit        = 1'($urandom());
            tbl_rd_oq      = NQ'($urandom());
            tbl_rd_protect = 1'($urandom());
            tbl_rd_mac     = rand_mac();
            if (!tbl_req) begin
                wait_cnt = 0;
            end else if (wait_cnt < tbl_delay) begin
                wait_cnt++;
            end else begin
                wait_cnt = 0;
                tbl_done = 1'b1;
                case (tbl_op)
                    2'b00: begin
                        tbl_hit = 1'b0;
                        for (int i = 0; i < DEPTH; i++)
                            if (!tbl_hit && mem_vld[i] && mem_mac[i] == tbl_mac) begin
                                tbl_hit = 1'b1; tbl_rd_oq = mem_oq[i];
                            end
                    end
                    2'b01: begin
                        tbl_hit = mem_vld[tbl_addr]; tbl_rd_oq = mem_oq[tbl_addr];
                        tbl_rd_protect = mem_prot[tbl_addr]; tbl_rd_mac = mem_mac[tbl_addr];
                    end
                    2'b10: begin
                        mem_mac[tbl_addr] = tbl_mac; mem_oq[tbl_addr] = tbl_oq;
                        mem_prot[tbl_addr] = tbl_protect; mem_vld[tbl_addr] = 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    task automatic lookup(input logic [47:0] mac, input int dly);
        logic exp_hit; logic [NQ-1:0] exp_oq; logic got_hit; logic [NQ-1:0] got_oq;
        int lat, hits, misses; bit got, coincide, field_err;
        exp_hit = 1'b0; exp_oq = '0;
        for (int i = 0; i < DEPTH; i++)
            if (!exp_hit && ref_vld[i] && ref_mac[i] == mac) begin exp_hit = 1'b1; exp_oq = ref_oq[i]; end
        tbl_delay = dly; lu_mac = mac; lu_req = 1'b1;
        lat = 0; hits = 0; misses = 0; got = 0; coincide = 0; field_err = 0; got_hit = 1'b0; got_oq = '0;
        while (!got && lat < 40) begin
            step(); lat++;
            hits += int'(lut_hit); misses += int'(lut_miss);
            if (lut_hit && lut_miss) coincide = 1;
            if (tbl_req && (tbl_op !== 2'b00 || tbl_mac !== mac)) field_err = 1;
            if (lu_ack) begin got = 1; got_hit = lu_hit; got_oq = lu_oq; lu_req = 1'b0; end
        end
        step();
        hits += int'(lut_hit); misses += int'(lut_miss);
        total++; if (!got || lat != dly + 2) begin bad++; $display("FAIL lu_latency: got=%0d lat=%0d want %0d", got, lat, dly + 2); end
        total++; if (field_err) begin bad++; $display("FAIL lu_cmd_fields: op=%b mac=%h want 00/%h", tbl_op, tbl_mac, mac); end
        total++; if (got_hit !== exp_hit || got_oq !== exp_oq) begin bad++; $display("FAIL lu_result: hit=%b oq=%b want %b/%b", got_hit, got_oq, exp_hit, exp_oq); end
        total++; if (hits != int'(exp_hit) || misses != int'(!exp_hit) || coincide) begin bad++; $display("FAIL lut_pulses: hits=%0d misses=%0d want %0d/%0d", hits, misses, int'(exp_hit), int'(!exp_hit)); end
        total++; if (lu_ack !== 1'b0) begin bad++; $display("FAIL lu_ack_width: ack=%b want 0", lu_ack); end
    endtask

    task automatic reg_write(input logic [AW-1:0] a, input logic [47:0] m, input logic [NQ-1:0] q, input logic p, input int dly);
        int lat; bit got, field_err;
        tbl_delay = dly;
        reg_wr_addr = a; reg_wr_mac = m; reg_wr_oq = q; reg_wr_protect = p; reg_wr_req = 1'b1;
        lat = 0; got = 0; field_err = 0;
        while (!got && lat < 40) begin
            step(); lat++;
            if (tbl_req && {tbl_op, tbl_addr, tbl_mac, tbl_oq, tbl_protect} !== {2'b10, a, m, q, p}) field_err = 1;
            if (reg_wr_ack) got = 1;
        end
        total++; if (!got || lat != dly + 2) begin bad++; $display("FAIL wr_latency: got=%0d lat=%0d want %0d", got, lat, dly + 2); end
        total++; if (field_err) begin bad++; $display("FAIL wr_cmd_fields: addr=%h mac=%h want %h/%h", tbl_addr, tbl_mac, a, m); end
        repeat (2) step();
        total++; if (reg_wr_ack !== 1'b1) begin bad++; $display("FAIL wr_ack_hold: ack=%b want 1", reg_wr_ack); end
        reg_wr_req = 1'b0;
        step();
        total++; if (reg_wr_ack !== 1'b0) begin bad++; $display("FAIL wr_ack_release: ack=%b want 0", reg_wr_ack); end
        ref_mac[a] = m; ref_oq[a] = q; ref_prot[a] = p; ref_vld[a] = 1'b1;
    endtask

    task automatic reg_read(input logic [AW-1:0] a, input int dly);
        int lat; bit got, field_err; logic [NQ+48:0] exp_d, got_d;
        exp_d = {ref_prot[a], ref_oq[a], ref_mac[a]};
        tbl_delay = dly; reg_rd_addr = a; reg_rd_req = 1'b1;
        lat = 0; got = 0; field_err = 0; got_d = '0;
        while (!got && lat < 40) begin
            step(); lat++;
            if (tbl_req && {tbl_op, tbl_addr} !== {2'b01, a}) field_err = 1;
            if (reg_rd_ack) begin got = 1; got_d = {reg_rd_protect, reg_rd_oq, reg_rd_mac}; end
        end
        total++; if (!got || lat != dly + 2) begin bad++; $display("FAIL rd_latency: got=%0d lat=%0d want %0d", got, lat, dly + 2); end
        total++; if (field_err) begin bad++; $display("FAIL rd_cmd_fields: op=%b addr=%h want 01/%h", tbl_op, tbl_addr, a); end
        total++; if (got_d !== exp_d) begin bad++; $display("FAIL rd_data: got %h want %h", got_d, exp_d); end
        repeat (3) step();
        total++; if (reg_rd_ack !== 1'b1 || {reg_rd_protect, reg_rd_oq, reg_rd_mac} !== exp_d) begin bad++; $display("FAIL rd_hold: ack=%b data=%h want 1/%h", reg_rd_ack, {reg_rd_protect, reg_rd_oq, reg_rd_mac}, exp_d); end
        reg_rd_req = 1'b0;
        step();
        total++; if (reg_rd_ack !== 1'b0) begin bad++; $display("FAIL rd_ack_release: ack=%b want 0", reg_rd_ack); end
    endtask

    task automatic learn(input logic [AW-1:0] a, input logic [47:0] m, input logic [NQ-1:0] q, input int dly);
        int lat, issue_cycles; bit got, field_err, done_seen;
        tbl_delay = dly; lrn_addr = a; lrn_mac = m; lrn_oq = q; lrn_req = 1'b1;
        lat = 0; got = 0; field_err = 0; issue_cycles = 0; done_seen = 0;
        while (!got && lat < 40) begin
            step(); lat++;
            if (tbl_req) begin
                issue_cycles++;
                if ({tbl_op, tbl_addr, tbl_mac, tbl_oq, tbl_protect} !== {2'b10, a, m, q, 1'b0}) field_err = 1;
            end
            if (lrn_ack) begin got = 1; lrn_req = 1'b0; end
        end
        step();
        total++; if (!got || lat != dly + 2) begin bad++; $display("FAIL lrn_latency: got=%0d lat=%0d want %0d", got, lat, dly + 2); end
        total++; if (field_err || issue_cycles != dly + 1) begin bad++; $display("FAIL lrn_cmd_stable: err=%0d issue=%0d want 0/%0d", field_err, issue_cycles, dly + 1); end
        total++; if (lrn_ack !== 1'b0) begin bad++; $display("FAIL lrn_ack_width: ack=%b want 0", lrn_ack); end
        ref_mac[a] = m; ref_oq[a] = q; ref_prot[a] = 1'b0; ref_vld[a] = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) step();
        total++; if ({tbl_req, tbl_op, lu_ack, lrn_ack, reg_wr_ack, reg_rd_ack, lut_hit, lut_miss, lu_hit, lu_oq, reg_rd_oq, reg_rd_mac} !== '0) begin
            bad++; $display("FAIL reset_outputs: tbl_req=%b acks=%b%b%b%b want all 0", tbl_req, lu_ack, lrn_ack, reg_wr_ack, reg_rd_ack); end
        reset = 1'b0;
        step();
        total++; if ({tbl_req, lu_ack, lrn_ack, reg_wr_ack, reg_rd_ack} !== 5'b0) begin bad++; $display("FAIL post_reset_idle: tbl_req=%b want 0", tbl_req); end
    endtask

    task automatic test_stray_done();
        #2 tbl_done = 1'b1;
        step();
        step();
        total++; if ({tbl_req, lu_ack, lrn_ack, reg_wr_ack, reg_rd_ack, lut_hit, lut_miss} !== 7'b0) begin bad++; $display("FAIL stray_done: tbl_req=%b acks nonzero want 0", tbl_req); end
    endtask

    task automatic test_lookup_hit();
        logic [47:0] m;
        m = rand_mac();
        reg_write(4'd2, m, 5'b00100, 1'b0, 0);
        lookup(m, 0);
    endtask

    task automatic test_lookup_miss();
        lookup(rand_mac(), 1);
    endtask

    task automatic test_priority();
        tbl_delay = 0; reg_rd_addr = 4'd3; lu_mac = ref_mac[2]; lu_req = 1'b1; reg_rd_req = 1'b1;
        step();
        total++; if (tbl_req !== 1'b1 || tbl_op !== 2'b00) begin bad++; $display("FAIL prio_first: req=%b op=%b want 1/00", tbl_req, tbl_op); end
        step();
        total++; if (lu_ack !== 1'b1 || lu_oq !== 5'b00100) begin bad++; $display("FAIL prio_lu_ack: ack=%b oq=%b want 1/00100", lu_ack, lu_oq); end
        lu_req = 1'b0;
        step(); step();
        total++; if (tbl_req !== 1'b1 || tbl_op !== 2'b01 || tbl_addr !== 4'd3) begin bad++; $display("FAIL prio_second: op=%b addr=%h want 01/3", tbl_op, tbl_addr); end
        step();
        repeat (4) begin
            total++; if (reg_rd_ack !== 1'b1 || reg_rd_mac !== ref_mac[3]) begin bad++; $display("FAIL prio_rd_hold: ack=%b mac=%h want 1/%h", reg_rd_ack, reg_rd_mac, ref_mac[3]); end
            step();
        end
        reg_rd_req = 1'b0;
        step();
        total++; if (reg_rd_ack !== 1'b0) begin bad++; $display("FAIL prio_rd_release: ack=%b want 0", reg_rd_ack); end
    endtask

    task automatic test_starve();
        int lu_cnt, lu_before; bit granted; logic [47:0] m;
        m = rand_mac();
        tbl_delay = 0; lu_mac = rand_mac();
        reg_wr_addr = 4'd9; reg_wr_mac = m; reg_wr_oq = 5'b10001; reg_wr_protect = 1'b1;
        lu_req = 1'b1; reg_wr_req = 1'b1;
        lu_cnt = 0; lu_before = -1; granted = 0;
        for (int c = 0; c < 60; c++) begin
            step();
            if (lu_ack) lu_cnt++;
            if (tbl_req && tbl_op == 2'b10 && !granted) begin granted = 1; lu_before = lu_cnt; end
        end
`ifdef MAC_LUT_ARB_STARVE_GUARD_EN
        total++; if (!granted || lu_before != 8) begin bad++; $display("FAIL starve_guard: granted=%0d after %0d lookups want 1/8", granted, lu_before); end
        total++; if (reg_wr_ack !== 1'b1) begin bad++; $display("FAIL starve_wr_ack: ack=%b want 1", reg_wr_ack); end
        ref_mac[9] = m; ref_oq[9] = 5'b10001; ref_prot[9] = 1'b1; ref_vld[9] = 1'b1;
`else
        total++; if (granted || lu_cnt != 20) begin bad++; $display("FAIL starve_strict: granted=%0d lookups=%0d want 0/20", granted, lu_cnt); end
`endif
        lu_req = 1'b0; reg_wr_req = 1'b0;
        repeat (3) step();
        total++; if ({tbl_req, reg_wr_ack, lu_ack} !== 3'b0) begin bad++; $display("FAIL starve_drain: tbl_req=%b ack=%b want 0", tbl_req, reg_wr_ack); end
    endtask

    task automatic test_learn_delay();
        learn(4'd7, rand_mac(), 5'b01010, 4);
        reg_read(4'd7, 2);
    endtask

    task automatic test_reset_issue();
        logic [47:0] m;
        m = rand_mac();
        tbl_delay = 50; lrn_addr = 4'd5; lrn_mac = m; lrn_oq = 5'b11000; lrn_req = 1'b1;
        step(); step();
        total++; if (tbl_req !== 1'b1) begin bad++; $display("FAIL rst_pre_issue: tbl_req=%b want 1", tbl_req); end
        #2 reset = 1'b1;
        #1;
        total++; if ({tbl_req, lu_ack, lrn_ack, reg_wr_ack, reg_rd_ack, lut_hit, lut_miss} !== 7'b0) begin bad++; $display("FAIL rst_async: tbl_req=%b want 0", tbl_req); end
        step();
        reset = 1'b0; tbl_delay = 0;
        step();
        total++; if (tbl_req !== 1'b1 || tbl_op !== 2'b10 || tbl_addr !== 4'd5) begin bad++; $display("FAIL rst_rearb: req=%b op=%b addr=%h want 1/10/5", tbl_req, tbl_op, tbl_addr); end
        step();
        total++; if (lrn_ack !== 1'b1) begin bad++; $display("FAIL rst_lrn_ack: ack=%b want 1", lrn_ack); end
        lrn_req = 1'b0;
        step();
        ref_mac[5] = m; ref_oq[5] = 5'b11000; ref_prot[5] = 1'b0; ref_vld[5] = 1'b1;
    endtask

    task automatic test_random();
        int kind, dly; logic [AW-1:0] a;
        for (int n = 0; n < 30; n++) begin
            kind = int'($urandom_range(0, 4)); dly = int'($urandom_range(0, 3)); a = AW'($urandom());
            case (kind)
                0: lookup(ref_vld[a] ? ref_mac[a] : rand_mac(), dly);
                1: lookup(rand_mac(), dly);
                2: reg_write(a, rand_mac(), NQ'($urandom()), 1'($urandom()), dly);
                3: learn(a, rand_mac(), NQ'($urandom()), dly);
                default: reg_read(a, dly);
            endcase
        end
    endtask

    initial begin
        total = 0; bad = 0; tbl_delay = 0;
        reset = 1'b1;
        lu_req = 1'b0; lu_mac = 48'h0;
        lrn_req = 1'b0; lrn_addr = '0; lrn_mac = 48'h0; lrn_oq = '0;
        reg_wr_req = 1'b0; reg_wr_addr = '0; reg_wr_oq = '0; reg_wr_protect = 1'b0; reg_wr_mac = 48'h0;
        reg_rd_req = 1'b0; reg_rd_addr = '0;
        for (int i = 0; i < DEPTH; i++) begin
            ref_mac[i] = 48'h0; ref_oq[i] = '0; ref_prot[i] = 1'b0; ref_vld[i] = 1'b0;
        end
        test_reset();
        test_stray_done();
        reg_write(4'd3, rand_mac(), 5'b00011, 1'b1, 1);
        test_lookup_hit();
        test_lookup_miss();
        test_priority();
        test_learn_delay();
        test_starve();
        test_reset_issue();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
